// File: rtl/immgen_pkg.sv
// Shared immediate-select encodings and the sign-extension helper for the immgen pipeline.
// No logic of its own: no latency, no backpressure.
// Defines the constants used by imm_extract and immgen_pipe.
package immgen_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] IMM_I   = 3'd0;
    localparam logic [SEL_W-1:0] IMM_S   = 3'd1;
    localparam logic [SEL_W-1:0] IMM_B   = 3'd2;
    localparam logic [SEL_W-1:0] IMM_U   = 3'd3;
    localparam logic [SEL_W-1:0] IMM_J   = 3'd4;
    localparam logic [SEL_W-1:0] IMM_Z   = 3'd5;
    localparam logic [SEL_W-1:0] IMM_SH  = 3'd6;
    localparam logic [SEL_W-1:0] IMM_RSV = 3'd7;

    // val holds a width-bit field in its low bits; the result is that field sign-extended to 64 bits.
    function automatic logic [63:0] sext(input logic [31:0] val, input int unsigned width);
        logic [63:0] wide;
        wide = {val << (32 - width), 32'b0};
        return 64'($signed(wide) >>> (64 - width));
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for all RV32/RV64 base formats plus zimm and shamt.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline owns all flow control.
module imm_extract
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      inst,
    input  logic [SEL_W-1:0] immsel,
    output logic [XLEN-1:0]  imm,
    output logic             err
);

    // The opcode field carries no immediate bits in any format.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (immsel)
            IMM_I:  imm = XLEN'(sext({20'b0, inst[31:20]}, 12));
            IMM_S:  imm = XLEN'(sext({20'b0, inst[31:25], inst[11:7]}, 12));
            IMM_B:  imm = XLEN'(sext({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13));
            IMM_U:  imm = XLEN'(sext({inst[31:12], 12'b0}, 32));
            IMM_J:  imm = XLEN'(sext({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21));
            IMM_Z:  imm = XLEN'(inst[19:15]);
            // RV64 shift amounts carry one extra bit.
            IMM_SH: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default: begin
                imm = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/immgen_pipe.sv
// Two-stage valid/ready immediate generator between decode and execute; IMMGEN_TARGET_EN adds pc+imm.
// Latency: 2 cycles from accept to out_valid; 1 entry/cycle sustained when out_ready=1.
// Backpressure: in_ready = !s1_valid | !s2_valid | out_ready; outputs hold while stalled; flush drops all.
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [SEL_W-1:0] in_immsel,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic             out_err
);

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .inst   (in_inst),
        .immsel (in_immsel),
        .imm    (ext_imm),
        .err    (ext_err)
    );

    logic            s1_valid;
    logic            s2_valid;
    logic            s1_adv;
    logic            s2_adv;
    logic [XLEN-1:0] s1_imm;
    logic            s1_err;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // Data registers move only with their stage, so a stalled entry stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_imm <= '0;
            s1_err <= 1'b0;
        end else if (s1_adv && in_valid) begin
            s1_imm <= ext_imm;
            s1_err <= ext_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_imm <= '0;
            out_err <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            out_imm <= s1_imm;
            out_err <= s1_err;
        end
    end

`ifdef IMMGEN_TARGET_EN
    logic [XLEN-1:0] s1_pc;
    logic [XLEN-1:0] s2_target_nxt;

    // Wraps modulo 2^XLEN; the carry is intentionally dropped.
    assign s2_target_nxt = s1_pc + s1_imm;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_pc <= '0;
        end else if (s1_adv && in_valid) begin
            s1_pc <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_target <= '0;
        end else if (s2_adv && s1_valid) begin
            out_target <= s2_target_nxt;
        end
    end
`else
    logic unused_pc;
    assign unused_pc  = ^in_pc;
    assign out_target = '0;
`endif

endmodule

// File: tb/tb_immgen_pipe.sv
// Scoreboard bench: drives RV32 and RV64 instances with identical directed vectors;
// per-instance monitors pop expected entries whenever an output transfer occurs.
module tb_immgen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_immsel;
    logic [31:0] in_pc;
    logic [63:0] pc64;
    logic        out_ready;

    logic        ir32, ov32, oe32;
    logic [31:0] oi32, ot32;
    logic        ir64, ov64, oe64;
    logic [63:0] oi64, ot64;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;

    assign pc64 = {32'b0, in_pc};

    immgen_pipe #(.XLEN(32), .SEL_W(3)) u32 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (ir32),
        .in_inst    (in_inst),
        .in_immsel  (in_immsel),
        .in_pc      (in_pc),
        .out_valid  (ov32),
        .out_ready  (out_ready),
        .out_imm    (oi32),
        .out_target (ot32),
        .out_err    (oe32)
    );

    immgen_pipe #(.XLEN(64), .SEL_W(3)) u64 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (ir64),
        .in_inst    (in_inst),
        .in_immsel  (in_immsel),
        .in_pc      (pc64),
        .out_valid  (ov64),
        .out_ready  (out_ready),
        .out_imm    (oi64),
        .out_target (ot64),
        .out_err    (oe64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one entry, holds it until accepted, then pushes the expected outputs for both widths.
    task automatic send(input logic [31:0] inst, input logic [2:0] sel, input logic [31:0] pc,
                        input logic [31:0] e32, input logic [63:0] e64, input logic eerr);
        exp_t x;
        int   n;
        logic acc;
        in_valid  = 1'b1;
        in_inst   = inst;
        in_immsel = sel;
        in_pc     = pc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ir32;
            @(posedge clk);
            n++;
        end
        if (n > 1) stalls++;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            x.err = eerr;
            x.imm = 64'(e32);
`ifdef IMMGEN_TARGET_EN
            x.tgt = 64'(pc + e32);
`else
            x.tgt = '0;
`endif
            q32.push_back(x);
            x.imm = e64;
`ifdef IMMGEN_TARGET_EN
            x.tgt = {32'b0, pc} + e64;
`else
            x.tgt = '0;
`endif
            q64.push_back(x);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_q32", 64'(q32.size()), 64'd0);
        chk("drain_q64", 64'(q64.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov32 && out_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon32_unexpected: got imm %h expected no output", oi32);
            end else begin
                e = q32.pop_front();
                chk("mon32_imm", 64'(oi32), e.imm);
                chk("mon32_target", 64'(ot32), e.tgt);
                chk("mon32_err", 64'(oe32), 64'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov64 && out_ready) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon64_unexpected: got imm %h expected no output", oi64);
            end else begin
                e = q64.pop_front();
                chk("mon64_imm", oi64, e.imm);
                chk("mon64_target", ot64, e.tgt);
                chk("mon64_err", 64'(oe64), 64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_immsel = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid32", 64'(ov32), 64'd0);
        chk("rst_out_imm32", 64'(oi32), 64'd0);
        chk("rst_out_target32", 64'(ot32), 64'd0);
        chk("rst_out_err32", 64'(oe32), 64'd0);
        chk("rst_out_valid64", 64'(ov64), 64'd0);
        chk("rst_out_imm64", oi64, 64'd0);
        chk("rst_out_target64", ot64, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // I-type with first-entry latency: not visible after one edge, visible after two.
        send(32'hFFF00093, 3'd0, 32'h0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        @(negedge clk);
        chk("lat_one_edge", 64'(ov32), 64'd0);
        @(negedge clk);
        chk("lat_two_edges", 64'(ov32), 64'd1);
        @(posedge clk);
        #1;

        send(32'hFE000EE3, 3'd2, 32'h100, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(32'hFE112E23, 3'd1, 32'h200, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        drain();

        // J/U/Z back-to-back: no stall expected at full throughput.
        stalls = 0;
        send(32'h0010006F, 3'd4, 32'h300, 32'h00000800, 64'h0000000000000800, 1'b0);
        send(32'h123450B7, 3'd3, 32'h0,   32'h12345000, 64'h0000000012345000, 1'b0);
        send(32'h0007D073, 3'd5, 32'h0,   32'h0000000F, 64'h000000000000000F, 1'b0);
        send(32'h03F01013, 3'd6, 32'h0,   32'h0000001F, 64'h000000000000003F, 1'b0);
        send(32'h800000B7, 3'd3, 32'h0,   32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send(32'hFFFFFFFF, 3'd7, 32'h40,  32'h00000000, 64'h0000000000000000, 1'b1);
        chk("throughput_stalls", 64'(stalls), 64'd0);
        drain();

        // Backpressure: two accepted, then in_ready drops and the head entry holds.
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 32'h400, 32'h1, 64'h1, 1'b0);
        send(32'h00200093, 3'd0, 32'h404, 32'h2, 64'h2, 1'b0);
        in_valid  = 1'b1;
        in_inst   = 32'h00300093;
        in_immsel = 3'd0;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(ir32), 64'd0);
        chk("bp_out_valid", 64'(ov32), 64'd1);
        chk("bp_head_imm", 64'(oi32), 64'd1);
        repeat (3) @(negedge clk);
        chk("bp_head_hold32", 64'(oi32), 64'd1);
        chk("bp_head_hold64", oi64, 64'd1);
        chk("bp_in_ready_hold", 64'(ir32), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h00300093, 3'd0, 32'h408, 32'h3, 64'h3, 1'b0);
        send(32'h00400093, 3'd0, 32'h40C, 32'h4, 64'h4, 1'b0);
        drain();

        // Flush with A at the output, B in S1 and C presented: A transfers, B and C vanish.
        send(32'h00500093, 3'd0, 32'h500, 32'h5, 64'h5, 1'b0);
        send(32'h00600093, 3'd0, 32'h504, 32'h6, 64'h6, 1'b0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h00700093;
        in_immsel = 3'd0;
        @(negedge clk);
        chk("flush_in_ready", 64'(ir32), 64'd1);
        @(posedge clk);
        #1;
        q32.delete();
        q64.delete();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid32", 64'(ov32), 64'd0);
        chk("flush_out_valid64", 64'(ov64), 64'd0);
        chk("flush_s1_empty", 64'(u32.s1_valid), 64'd0);
        @(posedge clk);
        #1;
        send(32'h00800093, 3'd0, 32'h508, 32'h8, 64'h8, 1'b0);
        @(negedge clk);
        chk("post_flush_lat1", 64'(ov32), 64'd0);
        @(negedge clk);
        chk("post_flush_lat2", 64'(ov32), 64'd1);
        drain();

        // Reset mid-stream discards everything and zeroes the outputs.
        send(32'h00900093, 3'd0, 32'h600, 32'h9, 64'h9, 1'b0);
        send(32'h00A00093, 3'd0, 32'h604, 32'hA, 64'hA, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q32.delete();
        q64.delete();
        @(negedge clk);
        chk("midrst_out_valid32", 64'(ov32), 64'd0);
        chk("midrst_out_imm32", 64'(oi32), 64'd0);
        chk("midrst_out_target32", 64'(ot32), 64'd0);
        chk("midrst_out_valid64", 64'(ov64), 64'd0);
        chk("midrst_out_imm64", oi64, 64'd0);
        chk("midrst_out_target64", ot64, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(32'h00B00093, 3'd0, 32'h700, 32'hB, 64'hB, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator.
- Extracts and sign-/zero-extends the immediate for every RV32/RV64 base format, including CSR zimm and shift-amount forms.
- Optionally computes the branch/jump target (pc + imm).
- Sits between decode and execute, behind a two-stage valid/ready pipeline with stall and flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SEL_W, 3, width of the immediate-select field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all in-flight entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept input this cycle.
- in_inst  in  32  instruction word.
- in_immsel  in  SEL_W  immediate format select.
- in_pc  in  XLEN  pc of the instruction.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts output.
- out_imm  out  XLEN  extended immediate.
- out_target  out  XLEN  pc + imm (0 if feature off).
- out_err  out  1  reserved immsel was used.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Immsel encoding:
  - 0 I: sext(inst[31:20]).
  - 1 S: sext({inst[31:25],inst[11:7]}).
  - 2 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 3 U: sext({inst[31:12],12'b0}).
  - 4 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). J is always J; JALR uses I.
  - 5 Z: zext(inst[19:15]).
  - 6 SH: zext(inst[24:20]) for XLEN=32; zext(inst[25:20]) for XLEN=64.
  - 7: reserved. imm=0 and err=1.
- Sign extension is to XLEN; U-type is sign-extended on RV64.
- Stage 1 (S1): registers the extracted imm, err and pc.
- Stage 2 (S2): registers imm, err and target. Outputs are driven directly from the S2 registers.
- Latency: an entry accepted at edge N is presented at out_* after edge N+1, i.e. 2-cycle latency with no stall.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. It is combinational from out_ready; there is no combinational path from in_valid.
  - out_* hold stable while out_valid & !out_ready.
- Flush:
  - On the flush edge, s1_valid and s2_valid clear to 0.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - A same-cycle output transfer (out_valid & out_ready) still completes. The consumer must ignore it.
- Reset:
  - s1_valid, s2_valid, out_imm, out_target and out_err all go to 0.
  - Reset mid-stream discards all entries.
  - rst dominates flush.
- Data registers load only on stage advance, which holds them stable under stall.
- Target arithmetic is modulo 2^XLEN; the carry-out is discarded.

Optional Feature:
- Macro: IMMGEN_TARGET_EN.
- Defined: S2 computes out_target = s1_pc + s1_imm (XLEN-bit add) and registers it with the other S2 data.
- Undefined: no adder is built and pc is not stored. out_target is tied to 0. in_pc is unused.
- Latency and handshake are identical in both builds.

Decomposition:
- Package immgen_pkg:
  - Constants IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_Z=5, IMM_SH=6, IMM_RSV=7.
  - SEL_W=3.
  - Helper function for sign extension.
- One sub-module, imm_extract: purely combinational (inst, immsel) -> (imm, err), parametrised by XLEN. It is instantiated once, ahead of S1.
- immgen_pipe owns the pipeline registers, handshake, flush and the optional adder.

Test Plan:
- I/B decode, XLEN=32, feature on, out_ready=1:
  - inst=0xFFF00093, sel=0, pc=0x0 -> 2 cycles later out_imm=0xFFFFFFFF, err=0.
  - Next cycle: inst=0xFE000EE3, sel=2, pc=0x100 -> out_imm=0xFFFFFFFC, out_target=0x000000FC.
- J/U/Z:
  - 0x0010006F, sel=4 -> imm=0x00000800.
  - 0x123450B7, sel=3 -> 0x12345000.
  - 0x0007D073, sel=5 -> 0x0000000F.
  - Consecutive cycles -> one output per cycle, in order.
- Backpressure:
  - 4 back-to-back inputs with out_ready=0 -> in_ready falls after 2 accepted.
  - out_imm stays at entry 0.
  - Releasing out_ready -> entries 0,1,2,3 emerge in order, none lost or duplicated.
- Flush:
  - Flush with 2 entries in flight and in_valid=1 -> next cycle out_valid=0, s1 empty.
  - A new input 1 cycle later appears 2 cycles later.
- Reserved/reset:
  - sel=7 -> out_imm=0, out_err=1.
  - rst asserted mid-stream -> out_valid=0, out_imm=0, out_target=0 after that edge.
- XLEN=64:
  - 0xFFF00093, sel=0 -> imm=0xFFFFFFFFFFFFFFFF.
  - 0x03F01013, sel=6 -> imm=0x3F.
  - 0x800000B7, sel=3 -> 0xFFFFFFFF80000000.
